// File: rtl/bp_be_dcache_trace_checker.sv
// Multi-channel trace replay and response checker: replays trace words as dcache
// packets, tracks expected load data per channel and flags mismatches and timeouts.
module bp_be_dcache_trace_checker
  #(parameter int num_chan_p          = 1
  , parameter int data_width_p        = 64
  , parameter int paddr_width_p       = 56
  , parameter int page_offset_width_p = 12
  , parameter int opcode_width_p      = 4
  , parameter int outstanding_els_p   = 8
  , parameter int timeout_p           = 4096
  , parameter int count_width_p       = 32
  , localparam int ptag_width_lp  = paddr_width_p - page_offset_width_p
  , localparam int trace_width_lp = 2 + opcode_width_p + paddr_width_p + data_width_p
  )
  (input  logic                                       clk_i
  , input  logic                                      reset_i
  , input  logic                                      en_i
  , input  logic [count_width_p-1:0]                  instr_count_i
  , input  logic [num_chan_p-1:0]                     trace_v_i
  , input  logic [num_chan_p*trace_width_lp-1:0]      trace_data_i
  , output logic [num_chan_p-1:0]                     trace_yumi_o
  , output logic [num_chan_p-1:0]                     pkt_v_o
  , input  logic [num_chan_p-1:0]                     pkt_ready_i
  , output logic [num_chan_p*opcode_width_p-1:0]      pkt_opcode_o
  , output logic [num_chan_p*page_offset_width_p-1:0] pkt_page_offset_o
  , output logic [num_chan_p*ptag_width_lp-1:0]       pkt_ptag_o
  , output logic [num_chan_p*data_width_p-1:0]        pkt_data_o
  , input  logic [num_chan_p-1:0]                     resp_v_i
  , input  logic [num_chan_p*data_width_p-1:0]        resp_data_i
  , output logic [num_chan_p*count_width_p-1:0]       resp_count_o
  , output logic [num_chan_p*count_width_p-1:0]       mismatch_count_o
  , output logic [num_chan_p-1:0]                     done_o
  , output logic [num_chan_p-1:0]                     error_o
  , output logic [num_chan_p-1:0]                     timeout_o
  , output logic                                      all_done_o
  );

  localparam int ptr_width_lp    = $clog2(outstanding_els_p);
  localparam int tcount_width_lp = $clog2(timeout_p);
  localparam logic [ptr_width_lp:0]      depth_lp  = (ptr_width_lp+1)'(outstanding_els_p);
  localparam logic [tcount_width_lp-1:0] tlimit_lp = tcount_width_lp'(timeout_p - 1);

  for (genvar c = 0; c < num_chan_p; c++) begin : chan
    logic [trace_width_lp-1:0]  word;
    logic                       check, expect_resp, resp_v;
    logic [paddr_width_p-1:0]   paddr;
    logic [data_width_p-1:0]    wdata, rdata;
    logic [data_width_p:0]      mem [outstanding_els_p];
    logic [data_width_p:0]      head;
    logic [ptr_width_lp-1:0]    rd_ptr, wr_ptr;
    logic [ptr_width_lp:0]      used;
    logic                       full, empty, can_issue, pkt_v, yumi, enq, deq;
    logic                       mismatch, unexpected, overshoot, timeout_hit;
    logic [count_width_p-1:0]   resp_count, mismatch_count;
    logic [tcount_width_lp-1:0] tcount;
    logic                       error, timeout;

    assign word        = trace_data_i[c*trace_width_lp +: trace_width_lp];
    assign check       = word[trace_width_lp-1];
    assign expect_resp = word[trace_width_lp-2];
    assign paddr       = word[data_width_p +: paddr_width_p];
    assign wdata       = word[data_width_p-1:0];
    assign rdata       = resp_data_i[c*data_width_p +: data_width_p];
    assign resp_v      = resp_v_i[c];

    // Stores never wait on the FIFO; loads need a free slot before the edge.
    assign full      = (used == depth_lp);
    assign empty     = (used == '0);
    assign can_issue = ~full | ~expect_resp;
    assign pkt_v     = trace_v_i[c] & en_i & can_issue & ~reset_i;
    assign yumi      = pkt_v & pkt_ready_i[c];
    assign enq       = yumi & expect_resp;
    assign deq       = resp_v & ~empty;
    assign head      = mem[rd_ptr];

    assign mismatch    = deq & head[data_width_p] & (head[data_width_p-1:0] != rdata);
    assign unexpected  = resp_v & empty;
    assign overshoot   = deq & (resp_count >= instr_count_i);
    assign timeout_hit = ~resp_v & ~empty & (tcount == tlimit_lp);

    always_ff @(posedge clk_i) begin
      if (enq) mem[wr_ptr] <= {check, wdata};
    end

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        used   <= '0;
      end else begin
        if (enq) wr_ptr <= wr_ptr + 1'b1;
        if (deq) rd_ptr <= rd_ptr + 1'b1;
        if (enq & ~deq) used <= used + 1'b1;
        else if (deq & ~enq) used <= used - 1'b1;
      end
    end

    // Counters saturate; error and timeout stay set until reset.
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        resp_count     <= '0;
        mismatch_count <= '0;
        tcount         <= '0;
        error          <= 1'b0;
        timeout        <= 1'b0;
      end else begin
        if (deq & (resp_count != '1)) resp_count <= resp_count + 1'b1;
        if (mismatch & (mismatch_count != '1)) mismatch_count <= mismatch_count + 1'b1;
        if (resp_v | empty) tcount <= '0;
        else if (tcount != tlimit_lp) tcount <= tcount + 1'b1;
        if (timeout_hit) timeout <= 1'b1;
        if (mismatch | unexpected | overshoot | timeout_hit) error <= 1'b1;
      end
    end

    assign pkt_v_o[c]      = pkt_v;
    assign trace_yumi_o[c] = yumi;
    assign pkt_opcode_o[c*opcode_width_p +: opcode_width_p] =
      word[data_width_p+paddr_width_p +: opcode_width_p];
    assign pkt_page_offset_o[c*page_offset_width_p +: page_offset_width_p] =
      paddr[page_offset_width_p-1:0];
    assign pkt_ptag_o[c*ptag_width_lp +: ptag_width_lp] = paddr[paddr_width_p-1:page_offset_width_p];
    assign pkt_data_o[c*data_width_p +: data_width_p]   = wdata;
    assign resp_count_o[c*count_width_p +: count_width_p]     = resp_count;
    assign mismatch_count_o[c*count_width_p +: count_width_p] = mismatch_count;
    assign done_o[c]    = (resp_count == instr_count_i);
    assign error_o[c]   = error;
    assign timeout_o[c] = timeout;
  end

  assign all_done_o = &done_o;

endmodule
